// File: rtl/serial_receiver.sv
// Purpose : 8N1 UART-style receiver (optional even parity) that feeds the parallel-to-processor input.
// Latency : character_received pulses one cycle after the mid-stop-bit sample (~10 bit periods after the start edge).
// Backpressure: none. The serial line cannot be stalled, and each new character overwrites parallel_out.
//
// Ports:
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-high
//   serial_in           asynchronous serial line, idles high, LSB first
//   parallel_out[7:0]   last correctly framed character
//   character_received  1-cycle pulse when parallel_out is updated
//   framing_error       1-cycle pulse when the stop bit is sampled low
//   parity_error        1-cycle pulse on parity mismatch (constant 0 without parity)
//   busy                high whenever the FSM is not in IDLE
//
// Configuration macro: SERIAL_RECEIVER_PARITY_EN
//   Defined   : an even-parity bit sits between data bit 7 and the stop bit.
//   Undefined : there is no PARITY state, and parity_error is tied low.

module serial_receiver #(
  parameter int BIT_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] parallel_out,
  output logic       character_received,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_TICKS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_RECEIVER_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;

  logic            cnt_clr;
  logic            shift_en;
  logic            load_out;
  logic            fe_set;
`ifdef SERIAL_RECEIVER_PARITY_EN
  logic            par_cap;
  logic            pe_set;
  logic            par_bad;
`endif

  // Two-flop synchronizer. The flops reset to the idle (high) level, so a
  // reset never looks like a start edge by itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    load_out  = 1'b0;
    fe_set    = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
    par_cap   = 1'b0;
    pe_set    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_clr   = 1'b1;
        end
      end
      // Re-check the line at the middle of the start bit to reject glitches.
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      // Sampling is aligned to the bit centre because the START state
      // consumed half a bit period.
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (idx == 3'd7) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RECEIVER_PARITY_EN
      S_PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_clr   = 1'b1;
          par_cap   = 1'b1;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            state_nxt = S_IDLE;
`ifdef SERIAL_RECEIVER_PARITY_EN
            if (par_bad) pe_set   = 1'b1;
            else         load_out = 1'b1;
`else
            load_out = 1'b1;
`endif
          end else begin
            fe_set    = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      // A low line in BREAK must not count as a start edge. Wait for the
      // line to go high before arming again.
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit-period counter. It only runs while a frame is being timed, and every
  // terminal compare clears it, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (state == S_START || state == S_DATA ||
`ifdef SERIAL_RECEIVER_PARITY_EN
                 state == S_PARITY ||
`endif
                 state == S_STOP) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      if (shift_en) begin
        shreg <= {rx_s, shreg[7:1]};
        idx   <= idx + 3'd1;
      end else if (state != S_DATA) begin
        idx <= 3'd0;
      end
    end
  end

`ifdef SERIAL_RECEIVER_PARITY_EN
  // Even parity: the data bits plus the parity bit must hold an even count of ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 par_bad <= 1'b0;
    else if (state == S_START) par_bad <= 1'b0;
    else if (par_cap)          par_bad <= rx_s ^ (^shreg);
  end
`endif

  // Output register. It loads only from a complete, verified frame, so
  // shift-register contents from a partial frame are never visible here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_out       <= 8'h00;
      character_received <= 1'b0;
      framing_error      <= 1'b0;
    end else begin
      character_received <= load_out;
      framing_error      <= fe_set;
      if (load_out) parallel_out <= shreg;
    end
  end

`ifdef SERIAL_RECEIVER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_error <= 1'b0;
    else       parity_error <= pe_set;
  end
`else
  assign parity_error = 1'b0;
`endif

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Purpose : directed, table-driven bench for serial_receiver at BIT_TICKS=16.
// Latency : measures the interval from the start edge to character_received.
// Backpressure: not applicable (the design has no flow control).

module tb_serial_receiver;

  localparam int BT = 16;
`ifdef SERIAL_RECEIVER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT_LO = 152 + 16 * PAR;
  localparam int LAT_HI = 156 + 16 * PAR;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] parallel_out;
  logic       character_received;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  serial_receiver #(.BIT_TICKS(BT)) dut (
    .clk                (clk),
    .reset              (reset),
    .serial_in          (serial_in),
    .parallel_out       (parallel_out),
    .character_received (character_received),
    .framing_error      (framing_error),
    .parity_error       (parity_error),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  int cr_cnt = 0, fe_cnt = 0, pe_cnt = 0, cr_cyc = 0, multi = 0;
  int busy_drop = 0;
  int fall_cyc  = 0;
  always @(negedge clk) begin
    if (character_received) begin
      cr_cnt <= cr_cnt + 1;
      cr_cyc <= cyc;
    end
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (parity_error)  pe_cnt <= pe_cnt + 1;
    if (32'(character_received) + 32'(framing_error) + 32'(parity_error) > 1)
      multi <= multi + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    serial_in = v;
    for (int i = 0; i < BT; i++) begin
      @(negedge clk);
      if (i == BT / 2 && !busy) busy_drop++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR) drive_bit(par_v);
    drive_bit(stop_v);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         exp_char;
    int         exp_fe;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[8];

  int cr0, fe0, pe0;
  logic [7:0] out0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[6] = '{8'hC3, 1'b0, 0, 1, 8'h81};
    vecs[7] = '{8'h7E, 1'b1, 1, 0, 8'h7E};

    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_out",  parallel_out,       8'h00);
    check("reset_cr",   character_received, 1'b0);
    check("reset_fe",   framing_error,      1'b0);
    check("reset_pe",   parity_error,       1'b0);
    check("reset_busy", busy,               1'b0);
    idle(10);

    // Table of single frames separated by idle gaps.
    foreach (vecs[k]) begin
      cr0 = cr_cnt; fe0 = fe_cnt;
      send_frame(vecs[k].data, vecs[k].stop_v, ^vecs[k].data);
      idle(24);
      check($sformatf("vec%0d_cr", k),  cr_cnt - cr0, vecs[k].exp_char);
      check($sformatf("vec%0d_fe", k),  fe_cnt - fe0, vecs[k].exp_fe);
      check($sformatf("vec%0d_out", k), parallel_out, vecs[k].exp_out);
      check($sformatf("vec%0d_busy", k), busy, 1'b0);
      if (vecs[k].exp_char == 1)
        check_range($sformatf("vec%0d_latency", k), cr_cyc - fall_cyc, LAT_LO, LAT_HI);
    end

    // A short low glitch is rejected at the start-bit midpoint.
    cr0 = cr_cnt; fe0 = fe_cnt; out0 = parallel_out;
    serial_in = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    check("glitch_cr",   cr_cnt - cr0, 0);
    check("glitch_fe",   fe_cnt - fe0, 0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_out",  parallel_out, out0);

    // Stop bit low, then the line is held low: one framing error, no new frame.
    cr0 = cr_cnt; fe0 = fe_cnt; out0 = parallel_out;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    serial_in = 1'b0;
    repeat (40) @(negedge clk);
    check("break_busy_low", busy, 1'b1);
    check("break_fe_low",   fe_cnt - fe0, 1);
    idle(30);
    check("break_cr",   cr_cnt - cr0, 0);
    check("break_fe",   fe_cnt - fe0, 1);
    check("break_out",  parallel_out, out0);
    check("break_busy", busy, 1'b0);

    // Back-to-back frames with no idle gap.
    cr0 = cr_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    check("b2b_first_out", parallel_out, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(24);
    check("b2b_cr",  cr_cnt - cr0, 2);
    check("b2b_out", parallel_out, 8'hFF);

    // Reset asserted in the middle of data bit 4 of 0x55.
    serial_in = 1'b0;
    for (int i = 0; i < 5; i++) drive_bit((i == 0) ? 1'b0 : ((8'h55 >> (i - 1)) & 8'h01) != 0);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_out",  parallel_out, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cr",   character_received, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(30);
    cr0 = cr_cnt;
    send_frame(8'h81, 1'b1, 1'b0);
    idle(24);
    check("midrst_next_cr",  cr_cnt - cr0, 1);
    check("midrst_next_out", parallel_out, 8'h81);

`ifdef SERIAL_RECEIVER_PARITY_EN
    cr0 = cr_cnt; pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(24);
    check("par_good_cr",  cr_cnt - cr0, 1);
    check("par_good_pe",  pe_cnt - pe0, 0);
    check("par_good_out", parallel_out, 8'h07);
    cr0 = cr_cnt; pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(24);
    check("par_bad_pe",  pe_cnt - pe0, 1);
    check("par_bad_cr",  cr_cnt - cr0, 0);
    check("par_bad_out", parallel_out, 8'h07);
`else
    check("no_parity_pulses", pe_cnt, 0);
`endif

    check("pulse_exclusive", multi, 0);
    check("busy_in_frame",   busy_drop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
- REQ-001: BIT_TICKS, default 16; clock cycles per serial bit period; legal range 4..65535, even values only.
- REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: serial_in  input  1  asynchronous serial line; idles high; 8N1 frame, LSB first.
- REQ-005: parallel_out  output  8  last correctly framed character, feeding the processor's parallel-to-processor input.
- REQ-006: character_received  output  1  one-cycle pulse when parallel_out is updated.
- REQ-007: framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
- REQ-008: parity_error  output  1  one-cycle pulse on parity mismatch; tied 0 without the parity option.
- REQ-009: busy  output  1  high in every state except IDLE.

Function
- REQ-010: serial_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- REQ-011: States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK.
- REQ-012: IDLE: rx_s==0 -> START, with the tick counter cleared to 0.
- REQ-013: START: at counter == BIT_TICKS/2-1, sample rx_s.
  - If rx_s==1: return to IDLE; treat as a glitch with no output pulse.
  - Otherwise: clear the counter and the bit index, then go to DATA.
- REQ-014: DATA: at counter == BIT_TICKS-1, sample rx_s into bit[index] (LSB first), clear the counter and increment the index.
  - After bit 7: go to PARITY when parity is enabled, else to STOP.
- REQ-015: PARITY: at counter == BIT_TICKS-1, sample the parity bit, record the mismatch, then go to STOP.
- REQ-016: STOP: at counter == BIT_TICKS-1, sample rx_s.
  - Sample ==1, no parity mismatch: load parallel_out from the shift register and pulse character_received next cycle; go to IDLE.
  - Sample ==1, parity mismatch: pulse parity_error; parallel_out keeps its old value; go to IDLE.
  - Sample ==0: pulse framing_error; parallel_out keeps its old value; go to BREAK.
- REQ-017: BREAK: remain until rx_s==1, then go to IDLE; low time during BREAK SHALL NOT start a frame.
- REQ-018: The tick counter SHALL be wide enough for BIT_TICKS-1, with no wrap inside any state.
- REQ-019: parallel_out SHALL be stable between updates and never show partial shift-register contents.
- REQ-020: A new start edge occurring one cycle after returning to IDLE SHALL be accepted (back-to-back frames).
- REQ-021: At most one of character_received, framing_error and parity_error SHALL be high in any cycle.

Reset
- REQ-022: Reset SHALL force the following, regardless of state, including mid-frame:
  - state=IDLE;
  - parallel_out=8'h00;
  - all pulses 0 and busy 0;
  - counter and index 0;
  - synchronizer flops 1.
- REQ-023: After reset deasserts, a frame already in progress SHALL only be treated as new if a falling edge is seen in IDLE.

Configuration
- REQ-024: Macro SERIAL_RECEIVER_PARITY_EN.
  - Defined: the frame carries an even-parity bit between bit 7 and the stop bit, and PARITY is reachable.
  - Undefined: PARITY and its logic SHALL be absent, and parity_error SHALL be constant 0.

Verification (BIT_TICKS=16, parity disabled unless stated)
- REQ-025: Send frame 0xA5 -> parallel_out=8'hA5.
  - character_received: exactly one 1-cycle pulse, 152..156 cycles after the serial_in falling edge.
  - busy high throughout the frame.
- REQ-026: Drive serial_in low for 5 cycles, then high -> no pulse, state back to IDLE, parallel_out unchanged.
- REQ-027: Send 0x3C with the stop bit low, and hold the line low for 40 cycles, then high.
  - Response: framing_error pulses once; parallel_out stays at its previous value.
  - No frame starts until the line returns high.
- REQ-028: Send 0x00 then 0xFF back-to-back, with no idle gap -> two character_received pulses, parallel_out = 0x00 then 0xFF.
- REQ-029: Assert reset at bit 4 of frame 0x55 -> outputs return to reset values immediately; the next complete frame 0x81 is received correctly.
- REQ-030: With SERIAL_RECEIVER_PARITY_EN defined:
  - 0x07 sent with parity 1 -> character_received pulses.
  - 0x07 sent with parity 0 -> parity_error pulses; parallel_out unchanged.
